// File: rtl/dp_sequencer.sv
// dp_sequencer: fetch/decode sequencer driving the register-file/ALU datapath.
// Optional STEP_LIMIT_EN adds an instruction budget with a timeout flag.
module dp_sequencer #(
   parameter int PC_WIDTH  = 8,
   parameter int MAX_STEPS = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic [PC_WIDTH-1:0] pm_addr,
   output logic                pm_en,
   input  logic [23:0]         pm_data,
   input  logic                dp_halt,
   output logic                writeEnable,
   output logic                writeSourceSelect,
   output logic                muxASelect,
   output logic                muxBSelect,
   output logic [7:0]          extInputData,
   output logic [3:0]          destAddress,
   output logic [3:0]          aAddress,
   output logic [3:0]          bAddress,
   output logic [3:0]          aluOpCode,
   output logic                haltCondition,
   output logic                busy,
   output logic                done,
`ifdef STEP_LIMIT_EN
   output logic                timeout,
`endif
   output logic [PC_WIDTH-1:0] pc
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] FETCH = 3'd1;
   localparam logic [2:0] LATCH = 3'd2;
   localparam logic [2:0] EXEC  = 3'd3;
   localparam logic [2:0] HCHK  = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   logic [2:0]          state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [23:0]         ir_q, ir_d;
   logic [1:0]          cls;
   logic                ex, restart, limit;

   assign ex      = state_q == EXEC;
   assign cls     = ir_q[23:22];
   assign restart = start && (state_q == IDLE || state_q == DONE);

`ifdef STEP_LIMIT_EN
   localparam int SW = $clog2(MAX_STEPS + 1);
   logic [SW-1:0] step_q, step_d;
   logic          timeout_q, timeout_d;
   logic          unused_ir;
   assign limit     = ex && step_q == SW'(MAX_STEPS - 1);
   assign step_d    = restart ? '0 : ex ? step_q + SW'(1) : step_q;
   assign timeout_d = restart ? 1'b0 : limit ? 1'b1 : timeout_q;
   assign timeout   = timeout_q;
   assign unused_ir = ir_q[20];
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         step_q    <= step_d;
         timeout_q <= timeout_d;
      end
   end
`else
   logic unused_cfg;
   assign limit      = 1'b0;
   assign unused_cfg = ^{ir_q[20], MAX_STEPS > 0};
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         IDLE, DONE: if (start) begin
            state_d = FETCH;
            pc_d    = '0;
         end
         FETCH: state_d = LATCH;
         LATCH: begin
            ir_d    = pm_data;
            state_d = EXEC;
         end
         EXEC: if (limit) state_d = DONE;
            else if (cls == 2'b11) state_d = HCHK;
            else begin
               state_d = FETCH;
               pc_d    = pc_q + PC_WIDTH'(1);
            end
         HCHK: if (dp_halt) state_d = DONE;
            else begin
               state_d = FETCH;
               pc_d    = pc_q + PC_WIDTH'(1);
            end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // every datapath control is gated by EXEC so nothing leaks in other states
   assign writeEnable       = ex && cls != 2'b11;
   assign writeSourceSelect = ex && cls == 2'b10;
   assign muxASelect        = ex && cls == 2'b01 && ir_q[21];
   assign muxBSelect        = ex && cls == 2'b01 && !ir_q[21];
   assign haltCondition     = ex && cls == 2'b11;
   assign extInputData      = ex ? ir_q[7:0]   : '0;
   assign destAddress       = ex ? ir_q[15:12] : '0;
   assign aAddress          = ex ? ir_q[11:8]  : '0;
   assign bAddress          = ex ? ir_q[3:0]   : '0;
   assign aluOpCode         = ex ? ir_q[19:16] : '0;
   assign busy              = state_q inside {FETCH, LATCH, EXEC, HCHK};
   assign done              = state_q == DONE;
   assign pm_en             = state_q == FETCH;
   assign pm_addr           = pc_q;
   assign pc                = pc_q;
endmodule

// File: tb/tb_dp_sequencer.sv
// tb_dp_sequencer: directed bench with a ROM and a small register-file/ALU model.
module tb_dp_sequencer;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0;
   always #5 clk = ~clk;
   int pass_cnt = 0, total = 0;

   function automatic logic [23:0] ld(input logic [3:0] d, input logic [7:0] imm);
      return {2'b10, 2'b00, 4'h0, d, 4'h0, imm};
   endfunction
   function automatic logic [23:0] alu(input logic [3:0] op, input logic [3:0] d, input logic [3:0] a, input logic [3:0] b);
      return {2'b00, 2'b00, op, d, a, 4'h0, b};
   endfunction
   function automatic logic [23:0] alui(input logic ia, input logic [3:0] op, input logic [3:0] d, input logic [3:0] a, input logic [7:0] imm);
      return {2'b01, ia, 1'b1, op, d, a, imm};
   endfunction
   function automatic logic [23:0] hz(input logic [3:0] a);
      return {2'b11, 2'b00, 4'h0, 4'h0, a, 8'h00};
   endfunction

   logic [7:0]  pm_addr, extInputData, pc;
   logic [23:0] pm_data = '0;
   logic        pm_en, dp_halt, writeEnable, writeSourceSelect, muxASelect, muxBSelect, haltCondition, busy, done;
   logic [3:0]  destAddress, aAddress, bAddress, aluOpCode;
`ifdef STEP_LIMIT_EN
   logic        timeout;
`endif
   dp_sequencer #(.PC_WIDTH(8), .MAX_STEPS(255)) dut (
      .clk(clk), .rst(rst), .start(start), .pm_addr(pm_addr), .pm_en(pm_en), .pm_data(pm_data),
      .dp_halt(dp_halt), .writeEnable(writeEnable), .writeSourceSelect(writeSourceSelect),
      .muxASelect(muxASelect), .muxBSelect(muxBSelect), .extInputData(extInputData),
      .destAddress(destAddress), .aAddress(aAddress), .bAddress(bAddress), .aluOpCode(aluOpCode),
      .haltCondition(haltCondition), .busy(busy), .done(done),
`ifdef STEP_LIMIT_EN
      .timeout(timeout),
`endif
      .pc(pc));

   logic [23:0] rom [256];
   always @(posedge clk) if (pm_en) pm_data <= rom[pm_addr];

   logic [7:0] rf [16];
   logic [7:0] a_v, b_v, alu_v;
   logic       halt_q;
   always_comb begin
      a_v   = muxASelect ? extInputData : rf[aAddress];
      b_v   = muxBSelect ? extInputData : rf[bAddress];
      alu_v = aluOpCode == 4'h0 ? a_v + b_v : aluOpCode == 4'h1 ? a_v - b_v : a_v;
   end
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         halt_q <= 1'b0;
         for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
      end else begin
         if (writeEnable) rf[destAddress] <= writeSourceSelect ? extInputData : alu_v;
         if (haltCondition) halt_q <= rf[aAddress] == 8'h00;
      end
   end
   assign dp_halt = halt_q;

   logic [28:0] ctl;
   assign ctl = {writeEnable, writeSourceSelect, muxASelect, muxBSelect, haltCondition,
                 aluOpCode, destAddress, aAddress, bAddress, extInputData};

   // second instance with a 2-bit pc for the wrap scenario
   logic       start2 = 1'b0;
   logic [1:0] w_pm_addr, w_pc;
   logic [23:0] w_pm_data = '0;
   logic       w_pm_en, w_we, w_wss, w_ma, w_mb, w_hc, w_busy, w_done;
   logic [7:0] w_ext;
   logic [3:0] w_dest, w_aa, w_ba, w_op;
`ifdef STEP_LIMIT_EN
   logic       w_timeout;
`endif
   dp_sequencer #(.PC_WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .pm_addr(w_pm_addr), .pm_en(w_pm_en), .pm_data(w_pm_data),
      .dp_halt(1'b0), .writeEnable(w_we), .writeSourceSelect(w_wss), .muxASelect(w_ma),
      .muxBSelect(w_mb), .extInputData(w_ext), .destAddress(w_dest), .aAddress(w_aa),
      .bAddress(w_ba), .aluOpCode(w_op), .haltCondition(w_hc), .busy(w_busy), .done(w_done),
`ifdef STEP_LIMIT_EN
      .timeout(w_timeout),
`endif
      .pc(w_pc));
   logic [23:0] rom2 [4];
   always @(posedge clk) if (w_pm_en) w_pm_data <= rom2[w_pm_addr];

`ifdef STEP_LIMIT_EN
   logic       start3 = 1'b0;
   logic [7:0] s_pm_addr, s_pc, s_ext;
   logic [23:0] s_pm_data;
   logic       s_pm_en, s_we, s_wss, s_ma, s_mb, s_hc, s_busy, s_done, s_timeout;
   logic [3:0] s_dest, s_aa, s_ba, s_op;
   assign s_pm_data = ld(4'h1, 8'h07);
   dp_sequencer #(.PC_WIDTH(8), .MAX_STEPS(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .pm_addr(s_pm_addr), .pm_en(s_pm_en), .pm_data(s_pm_data),
      .dp_halt(1'b0), .writeEnable(s_we), .writeSourceSelect(s_wss), .muxASelect(s_ma),
      .muxBSelect(s_mb), .extInputData(s_ext), .destAddress(s_dest), .aAddress(s_aa),
      .bAddress(s_ba), .aluOpCode(s_op), .haltCondition(s_hc), .busy(s_busy), .done(s_done),
      .timeout(s_timeout), .pc(s_pc));
`endif

   logic [31:0] we_m, hc_m, done_m, busy_m, pmen_m;
   logic [7:0]  pc_at [32];
   logic [28:0] ctl_at [32];

   // cycle 1 is the first cycle after the edge that samples start
   task automatic go(input int n, input int pulse_at);
      we_m = '0; hc_m = '0; done_m = '0; busy_m = '0; pmen_m = '0;
      @(negedge clk); start = 1'b1;
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         start     = (c == pulse_at);
         we_m[c]   = writeEnable;
         hc_m[c]   = haltCondition;
         done_m[c] = done;
         busy_m[c] = busy;
         pmen_m[c] = pm_en;
         pc_at[c]  = pc;
         ctl_at[c] = ctl;
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      total++; if ({ctl, pm_en, busy, done} !== 32'h0) $display("FAIL reset_outputs got=%h exp=0", {ctl, pm_en, busy, done}); else pass_cnt++;
      total++; if (pc !== 8'h00) $display("FAIL reset_pc got=%h exp=00", pc); else pass_cnt++;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++; if ({busy, done, w_busy} !== 3'b000) $display("FAIL idle_after_reset got=%b exp=000", {busy, done, w_busy}); else pass_cnt++;
   endtask

   task automatic test_program;
      int bad = 0;
      rom[0] = ld(4'h1, 8'h05); rom[1] = ld(4'h2, 8'h03); rom[2] = alu(4'h0, 4'hF, 4'h1, 4'h2); rom[3] = hz(4'h0);
      go(14, 0);
      for (int c = 1; c <= 14; c++) if (c % 3 != 0 && ctl_at[c] !== 29'h0) bad++;
      total++; if (we_m !== 32'h248) $display("FAIL prog_we got=%h exp=%h", we_m, 32'h248); else pass_cnt++;
      total++; if (hc_m !== 32'h1000) $display("FAIL prog_hc got=%h exp=%h", hc_m, 32'h1000); else pass_cnt++;
      total++; if (pmen_m !== 32'h492) $display("FAIL prog_pm_en got=%h exp=%h", pmen_m, 32'h492); else pass_cnt++;
      total++; if (busy_m !== 32'h3FFE) $display("FAIL prog_busy got=%h exp=%h", busy_m, 32'h3FFE); else pass_cnt++;
      total++; if (done_m !== 32'h4000) $display("FAIL prog_done got=%h exp=%h", done_m, 32'h4000); else pass_cnt++;
      total++; if (ctl_at[9] !== {5'b10000, 4'h0, 4'hF, 4'h1, 4'h2, 8'h02}) $display("FAIL prog_alu_ctl got=%h", ctl_at[9]); else pass_cnt++;
      total++; if (bad !== 0) $display("FAIL prog_idle_ctl got=%0d exp=0", bad); else pass_cnt++;
      total++; if (rf[15] !== 8'h08) $display("FAIL prog_r15 got=%h exp=08", rf[15]); else pass_cnt++;
      total++; if (pc !== 8'h03) $display("FAIL prog_pc got=%h exp=03", pc); else pass_cnt++;
   endtask

   task automatic test_reset_mid_exec;
      logic seen = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (writeEnable !== 1'b1) $display("FAIL mid_we got=%b exp=1", writeEnable); else pass_cnt++;
      #2 rst = 1'b0;
      #1;
      total++; if ({ctl, pm_en, busy, done, pc} !== 40'h0) $display("FAIL mid_reset_outputs got=%h exp=0", {ctl, pm_en, busy, done, pc}); else pass_cnt++;
      @(negedge clk); rst = 1'b1;
      repeat (6) begin
         @(negedge clk);
         seen = seen | writeEnable | busy | done;
      end
      total++; if (seen !== 1'b0) $display("FAIL mid_after_release got=%b exp=0", seen); else pass_cnt++;
   endtask

   task automatic test_imm;
      rom[0] = ld(4'h1, 8'h05); rom[1] = alui(1'b0, 4'h0, 4'h4, 4'h1, 8'h10); rom[2] = hz(4'h0);
      go(11, 0);
      total++; if (ctl_at[6] !== {5'b10010, 4'h0, 4'h4, 4'h1, 4'h0, 8'h10}) $display("FAIL imm_ctl got=%h", ctl_at[6]); else pass_cnt++;
      total++; if (rf[4] !== 8'h15) $display("FAIL imm_r4 got=%h exp=15", rf[4]); else pass_cnt++;
      total++; if (done_m !== 32'h800) $display("FAIL imm_done got=%h exp=%h", done_m, 32'h800); else pass_cnt++;
   endtask

   task automatic test_haltz_continue;
      rom[0] = ld(4'h3, 8'h01); rom[1] = hz(4'h3); rom[2] = ld(4'h5, 8'h22); rom[3] = hz(4'h0);
      go(15, 4);
      total++; if (hc_m !== 32'h2040) $display("FAIL hz_hc got=%h exp=%h", hc_m, 32'h2040); else pass_cnt++;
      total++; if (we_m !== 32'h408) $display("FAIL hz_we got=%h exp=%h", we_m, 32'h408); else pass_cnt++;
      total++; if (busy_m !== 32'h7FFE) $display("FAIL hz_busy got=%h exp=%h", busy_m, 32'h7FFE); else pass_cnt++;
      total++; if (done_m !== 32'h8000) $display("FAIL hz_done got=%h exp=%h", done_m, 32'h8000); else pass_cnt++;
      total++; if ({pc_at[7], pc_at[8]} !== 16'h0102) $display("FAIL hz_pc_advance got=%h exp=0102", {pc_at[7], pc_at[8]}); else pass_cnt++;
      total++; if (rf[5] !== 8'h22) $display("FAIL hz_r5 got=%h exp=22", rf[5]); else pass_cnt++;
      total++; if (pc !== 8'h03) $display("FAIL hz_pc got=%h exp=03", pc); else pass_cnt++;
   endtask

   task automatic test_wrap;
      logic busy_all = 1'b1;
      logic [1:0] exp_pc;
      for (int i = 0; i < 4; i++) rom2[i] = ld(4'(i + 6), 8'(i));
      @(negedge clk); start2 = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         start2   = 1'b0;
         busy_all = busy_all & w_busy;
         if (c % 3 == 0) begin
            exp_pc = 2'((c / 3 - 1) % 4);
            total++; if ({w_we, w_pc} !== {1'b1, exp_pc}) $display("FAIL wrap_pc_c%0d got=%b exp=%b", c, {w_we, w_pc}, {1'b1, exp_pc}); else pass_cnt++;
         end
      end
      total++; if (busy_all !== 1'b1) $display("FAIL wrap_busy got=%b exp=1", busy_all); else pass_cnt++;
   endtask

`ifdef STEP_LIMIT_EN
   task automatic test_step_limit;
      @(negedge clk); start3 = 1'b1;
      @(negedge clk); start3 = 1'b0;
      repeat (8) @(negedge clk);
      total++; if ({s_we, s_timeout, s_done} !== 3'b100) $display("FAIL step_exec3 got=%b exp=100", {s_we, s_timeout, s_done}); else pass_cnt++;
      @(negedge clk);
      total++; if ({s_timeout, s_done, s_busy} !== 3'b110) $display("FAIL step_timeout got=%b exp=110", {s_timeout, s_done, s_busy}); else pass_cnt++;
      start3 = 1'b1;
      @(negedge clk); start3 = 1'b0;
      total++; if ({s_timeout, s_busy} !== 2'b01) $display("FAIL step_restart got=%b exp=01", {s_timeout, s_busy}); else pass_cnt++;
      total++; if (timeout !== 1'b0) $display("FAIL step_main_timeout got=%b exp=0", timeout); else pass_cnt++;
   endtask
`endif

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = '0;
      test_reset;
      test_program;
      test_reset_mid_exec;
      test_imm;
      test_haltz_continue;
      test_wrap;
`ifdef STEP_LIMIT_EN
      test_step_limit;
`endif
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule
